// File: rtl/timer_array_if.sv
// ---------------------------------------------------------------------------
// timer_array_if
// Memory-mapped slave bus used by the timer_array peripheral.
//   address     : word address, [AW-1:2] channel, [1:0] register
//   writedata   : 32-bit write data
//   write/read  : strobes, only meaningful while chipselect is high
//   chipselect  : slave select
//   readdata    : registered read data, valid the cycle after a read strobe
//   waitrequest : always low, the slave never stalls
// The master modport is the bus owner (core / testbench); the slave modport
// is the peripheral side.
// ---------------------------------------------------------------------------
interface timer_array_if #(
  parameter int AW = 5
);
  logic [AW-1:0] address;
  logic [31:0]   writedata;
  logic          write;
  logic          read;
  logic          chipselect;
  logic [31:0]   readdata;
  logic          waitrequest;

  modport master (
    output address, writedata, write, read, chipselect,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, writedata, write, read, chipselect,
    output readdata, waitrequest
  );
endinterface

// File: rtl/timer_array.sv
// ---------------------------------------------------------------------------
// timer_array
// Multi-channel up-counting timer. Every channel has a power-of-two
// prescaler, a compare register, periodic or one-shot mode, a sticky MATCH
// flag and an interrupt enable. Per-channel register map (address[1:0]):
//   0 CTRL    [0] EN, [1] PERIODIC, [2] IRQ_EN, [7:4] PS
//   1 COUNT
//   2 COMPARE
//   3 STATUS  [0] MATCH, write 1 to clear
// Ports:
//   clock  : single clock
//   resetn : asynchronous active-low reset
//   bus    : slave side of timer_array_if
//   irq    : OR over channels of MATCH & IRQ_EN
// ---------------------------------------------------------------------------
module timer_array #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32,
  parameter int AW     = 5
) (
  input  logic         clock,
  input  logic         resetn,
  timer_array_if.slave bus,
  output logic         irq
);

  localparam int CW = AW - 2;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_COUNT   = 2'd1;
  localparam logic [1:0] REG_COMPARE = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  logic             en       [NUM_CH];
  logic             periodic [NUM_CH];
  logic             irq_en   [NUM_CH];
  logic [3:0]       ps       [NUM_CH];
  logic [15:0]      pre      [NUM_CH];
  logic [WIDTH-1:0] count    [NUM_CH];
  logic [WIDTH-1:0] compare  [NUM_CH];
  logic             match    [NUM_CH];

  logic [CW-1:0] ch_sel;
  logic [1:0]    reg_sel;
  logic          wr_en;
  logic          rd_en;
  logic [31:0]   rd_value;
  logic [31:0]   rd_data;

  logic [NUM_CH-1:0] ctrl_wr;
  logic [NUM_CH-1:0] count_wr;
  logic [NUM_CH-1:0] compare_wr;
  logic [NUM_CH-1:0] status_clr;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] match_evt;

  assign ch_sel          = bus.address[AW-1:2];
  assign reg_sel         = bus.address[1:0];
  assign wr_en           = bus.write & bus.chipselect;
  assign rd_en           = bus.read & bus.chipselect;
  assign bus.readdata    = rd_data;
  assign bus.waitrequest = 1'b0;

  // Per-channel decode of bus writes and of the prescaler tick. Channel
  // numbers at or above NUM_CH never match, so those writes fall away.
  // A CTRL write restarts the prescaler and swallows a coincident tick; a
  // COUNT write overrides whatever the tick would have done, so in both
  // cases no match is evaluated.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ctrl_wr[c]    = wr_en && (ch_sel == CW'(c)) && (reg_sel == REG_CTRL);
      count_wr[c]   = wr_en && (ch_sel == CW'(c)) && (reg_sel == REG_COUNT);
      compare_wr[c] = wr_en && (ch_sel == CW'(c)) && (reg_sel == REG_COMPARE);
      status_clr[c] = wr_en && (ch_sel == CW'(c)) && (reg_sel == REG_STATUS)
                      && bus.writedata[0];
      tick[c]       = en[c] && (pre[c] == ((16'h1 << ps[c]) - 16'h1));
      match_evt[c]  = tick[c] && !ctrl_wr[c] && !count_wr[c]
                      && (count[c] == compare[c]);
    end
  end

  // Channel state. The MATCH set is placed after the write-1-clear so a
  // match in the same cycle as a clear leaves the flag high. COMPARE is
  // written with a non-blocking assignment, so a coincident match still
  // compares against the old value.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        en[c]       <= 1'b0;
        periodic[c] <= 1'b0;
        irq_en[c]   <= 1'b0;
        ps[c]       <= 4'd0;
        pre[c]      <= 16'd0;
        count[c]    <= '0;
        compare[c]  <= '0;
        match[c]    <= 1'b0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ctrl_wr[c]) begin
          en[c]       <= bus.writedata[0];
          periodic[c] <= bus.writedata[1];
          irq_en[c]   <= bus.writedata[2];
          ps[c]       <= bus.writedata[7:4];
          pre[c]      <= 16'd0;
        end else if (en[c]) begin
          pre[c] <= tick[c] ? 16'd0 : pre[c] + 16'd1;
        end

        if (count_wr[c]) begin
          count[c] <= bus.writedata[WIDTH-1:0];
        end else if (tick[c] && !ctrl_wr[c]) begin
          if (match_evt[c]) begin
            if (periodic[c]) begin
              count[c] <= '0;
            end else begin
              en[c] <= 1'b0;
            end
          end else begin
            count[c] <= count[c] + WIDTH'(1);
          end
        end

        if (compare_wr[c]) begin
          compare[c] <= bus.writedata[WIDTH-1:0];
        end

        if (status_clr[c]) begin
          match[c] <= 1'b0;
        end
        if (match_evt[c]) begin
          match[c] <= 1'b1;
        end
      end
    end
  end

  // Read mux over the current register contents, so a read in the same
  // cycle as a write or tick returns the value before that edge.
  always_comb begin
    rd_value = 32'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sel == CW'(c)) begin
        case (reg_sel)
          REG_CTRL:    rd_value = {24'd0, ps[c], 1'b0, irq_en[c], periodic[c], en[c]};
          REG_COUNT:   rd_value = 32'(count[c]);
          REG_COMPARE: rd_value = 32'(compare[c]);
          default:     rd_value = {31'd0, match[c]};
        endcase
      end
    end
  end

  // Registered read data, held between reads.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_data <= 32'd0;
    end else if (rd_en) begin
      rd_data <= rd_value;
    end
  end

  // Level interrupt: any channel with its flag set and interrupts enabled.
  always_comb begin
    irq = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      irq = irq | (match[c] & irq_en[c]);
    end
  end

endmodule

// File: tb/tb_timer_array.sv
// ---------------------------------------------------------------------------
// tb_timer_array
// Self-checking bench for timer_array. Expected read data is queued when a
// read is issued and popped by an independent monitor when the registered
// data appears; irq and waitrequest are compared every cycle against a
// reference model that derives ticks from elapsed cycles since the last
// CTRL write.
// ---------------------------------------------------------------------------
module tb_timer_array;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 32;
  localparam int AW     = 5;

  logic clock = 1'b0;
  logic resetn;
  logic irq;

  timer_array_if #(.AW(AW)) bus_if ();

  timer_array #(
    .NUM_CH(NUM_CH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus_if),
    .irq   (irq)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic             m_en    [NUM_CH];
  logic             m_per   [NUM_CH];
  logic             m_ie    [NUM_CH];
  logic [3:0]       m_ps    [NUM_CH];
  logic [WIDTH-1:0] m_cnt   [NUM_CH];
  logic [WIDTH-1:0] m_cmp   [NUM_CH];
  logic             m_match [NUM_CH];
  longint           m_start [NUM_CH];
  longint           edge_no = 0;
  logic             exp_irq = 1'b0;
  logic [31:0]      exp_q[$];
  bit               rd_seen = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr(input int ch, input int r);
    return AW'((ch << 2) | r);
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_en[c] = 1'b0; m_per[c] = 1'b0; m_ie[c] = 1'b0; m_ps[c] = 4'd0;
      m_cnt[c] = '0; m_cmp[c] = '0; m_match[c] = 1'b0; m_start[c] = 0;
    end
    exp_irq = 1'b0;
  endfunction

  function automatic logic [31:0] model_read(input logic [AW-1:0] a);
    int ch;
    ch = int'(a[AW-1:2]);
    if (ch >= NUM_CH) return 32'd0;
    case (a[1:0])
      2'd0:    return {24'd0, m_ps[ch], 1'b0, m_ie[ch], m_per[ch], m_en[ch]};
      2'd1:    return 32'(m_cnt[ch]);
      2'd2:    return 32'(m_cmp[ch]);
      default: return {31'd0, m_match[ch]};
    endcase
  endfunction

  // One clock edge of the model. A channel enabled by a CTRL write at edge S
  // ticks at edges S + k*2^PS (k >= 1) for as long as it stays enabled.
  function automatic void model_step(input bit wr, input logic [AW-1:0] a, input logic [31:0] d);
    int ch;
    int r;
    bit hit;
    bit tick;
    bit matched;
    longint period;
    ch = int'(a[AW-1:2]);
    r  = int'(a[1:0]);
    edge_no++;
    for (int c = 0; c < NUM_CH; c++) begin
      hit     = wr && (ch == c);
      matched = 1'b0;
      period  = longint'(1) << m_ps[c];
      tick    = m_en[c] && (edge_no > m_start[c]) && (((edge_no - m_start[c]) % period) == 0);
      if (hit && r == 0) begin
        m_en[c]    = d[0];
        m_per[c]   = d[1];
        m_ie[c]    = d[2];
        m_ps[c]    = d[7:4];
        m_start[c] = edge_no;
      end else begin
        if (hit && r == 1) begin
          m_cnt[c] = d[WIDTH-1:0];
        end else if (tick) begin
          if (m_cnt[c] == m_cmp[c]) begin
            matched = 1'b1;
            if (m_per[c]) m_cnt[c] = '0;
            else          m_en[c]  = 1'b0;
          end else begin
            m_cnt[c] = m_cnt[c] + 1;
          end
        end
      end
      if (hit && r == 2) m_cmp[c] = d[WIDTH-1:0];
      if (hit && r == 3 && d[0]) m_match[c] = 1'b0;
      if (matched) m_match[c] = 1'b1;
    end
    exp_irq = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (m_match[c] && m_ie[c]) exp_irq = 1'b1;
    end
  endfunction

  // Drives one bus cycle from a falling edge, advances the model at the
  // rising edge and returns at the next falling edge.
  task automatic apply_stimulus(input bit wr, input bit rd, input bit cs,
                                input logic [AW-1:0] a, input logic [31:0] d);
    bus_if.write      = wr;
    bus_if.read       = rd;
    bus_if.chipselect = cs;
    bus_if.address    = a;
    bus_if.writedata  = d;
    if (rd && cs) exp_q.push_back(model_read(a));
    @(posedge clock);
    model_step(wr && cs, a, d);
    @(negedge clock);
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d);
    apply_stimulus(1'b1, 1'b0, 1'b1, a, d);
  endtask

  task automatic bus_read(input logic [AW-1:0] a);
    apply_stimulus(1'b0, 1'b1, 1'b1, a, 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, '0, 32'd0);
  endtask

  task automatic bus_quiet();
    bus_if.write      = 1'b0;
    bus_if.read       = 1'b0;
    bus_if.chipselect = 1'b0;
    bus_if.address    = '0;
    bus_if.writedata  = 32'd0;
  endtask

  // Asynchronous reset asserted partway through a cycle.
  task automatic do_reset();
    bus_quiet();
    #2;
    resetn = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    check_output("readdata_after_reset", bus_if.readdata, 32'd0);
    check_output("irq_after_reset", {31'd0, irq}, 32'd0);
  endtask

  // Monitor: note which edges captured a read, then compare the registered
  // data and the interrupt line half a cycle later.
  always @(posedge clock) begin
    rd_seen = bus_if.read && bus_if.chipselect && resetn;
  end

  always @(negedge clock) begin
    check_output("irq", {31'd0, irq}, {31'd0, exp_irq});
    check_output("waitrequest", {31'd0, bus_if.waitrequest}, 32'd0);
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("[TB] FAIL readdata: got 0x%08h, expected no read pending", bus_if.readdata);
      end else begin
        check_output("readdata", bus_if.readdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    int op;
    int ch;
    int rg;
    logic [31:0] d;

    bus_quiet();
    model_reset();
    resetn = 1'b1;
    #1 resetn = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    check_output("reset_readdata", bus_if.readdata, 32'd0);
    check_output("reset_irq", {31'd0, irq}, 32'd0);

    // Periodic channel 0, PS=0 then PS=2
    bus_write(addr(0, 2), 32'd4);
    bus_write(addr(0, 0), 32'h03);
    for (int i = 0; i < 12; i++) bus_read(addr(0, 1));
    bus_read(addr(0, 3));
    bus_write(addr(0, 3), 32'd1);
    bus_write(addr(0, 0), 32'h23);
    for (int i = 0; i < 45; i++) begin
      if (i % 10 == 9)     bus_write(addr(0, 3), 32'd1);
      else if (i % 2 == 0) bus_read(addr(0, 1));
      else                 bus_read(addr(0, 3));
    end
    bus_write(addr(0, 0), 32'd0);

    // One-shot with interrupt, channel 1
    bus_write(addr(1, 2), 32'd9);
    bus_write(addr(1, 0), 32'h05);
    idle_cycles(11);
    bus_read(addr(1, 0));
    bus_read(addr(1, 1));
    bus_read(addr(1, 3));
    bus_write(addr(1, 3), 32'd1);
    idle_cycles(2);

    // Counter wrap through zero before matching, channel 2
    bus_write(addr(2, 2), 32'd2);
    bus_write(addr(2, 1), 32'hFFFF_FFFF);
    bus_write(addr(2, 0), 32'h01);
    for (int i = 0; i < 6; i++) bus_read(addr(2, 1));
    bus_read(addr(2, 3));

    // Clear in a match cycle, and COUNT write in a tick cycle, channel 3
    bus_write(addr(3, 2), 32'd0);
    bus_write(addr(3, 0), 32'h07);
    idle_cycles(2);
    bus_write(addr(3, 3), 32'd1);
    bus_read(addr(3, 3));
    bus_write(addr(3, 1), 32'd100);
    bus_read(addr(3, 1));
    bus_read(addr(3, 1));
    bus_write(addr(3, 0), 32'd0);
    bus_write(addr(3, 3), 32'd1);

    // Deselected write is ignored
    apply_stimulus(1'b1, 1'b0, 1'b0, addr(2, 2), 32'd55);
    bus_read(addr(2, 2));

    // All channels together, interrupts enabled on 0 and 2 only
    for (int c = 0; c < NUM_CH; c++) bus_write(addr(c, 3), 32'd1);
    for (int c = 0; c < NUM_CH; c++) begin
      bus_write(addr(c, 1), 32'd0);
      bus_write(addr(c, 2), 32'(4 - c));
      bus_write(addr(c, 0), 32'((c << 4) | ((c % 2 == 0) ? 7 : 3)));
    end
    for (int i = 0; i < 80; i++) begin
      if (i % 16 == 5)       bus_read(addr(5, 1));
      else if (i % 16 == 13) bus_read(addr(7, 0));
      else if (i % 2 == 0)   bus_read(addr(i % NUM_CH, 3));
      else                   bus_read(addr((i / 2) % NUM_CH, 1));
    end

    // Randomised traffic, including reads and writes in the same cycle
    for (int i = 0; i < 500; i++) begin
      op = int'($urandom_range(0, 9));
      ch = int'($urandom_range(0, 7));
      rg = int'($urandom_range(0, 3));
      case (rg)
        0:       d = ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
        1:       d = $urandom_range(0, 20);
        2:       d = $urandom_range(0, 15);
        default: d = $urandom_range(0, 1);
      endcase
      if (op < 6)       bus_read(addr(ch, rg));
      else if (op == 9) apply_stimulus(1'b1, 1'b1, 1'b1, addr(ch, rg), d);
      else              bus_write(addr(ch, rg), d);
    end

    // Reset mid-count with the interrupt raised
    bus_write(addr(3, 2), 32'd0);
    bus_write(addr(3, 0), 32'h07);
    idle_cycles(3);
    do_reset();
    bus_read(addr(3, 0));
    bus_read(addr(3, 1));
    idle_cycles(3);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("[TB] FAIL read_queue_drained: got %0d pending, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
